// File: rtl/data_mem_arb.sv
// data_mem_arb
//   Two-port round-robin arbiter in front of a single-port 256 x 8b data
//   memory. Port 0 is the core load/store port, port 1 the DMA/debug port.
//   A granted owner keeps the memory for back-to-back beats (a burst). On a
//   tie out of IDLE the port that did not own last wins.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_i, weN_i                access request, 1 = write / 0 = read
//   addrN_i, wdataN_i            access address and write data
//   gntN_o                       port N owns the memory (registered)
//   rvalidN_o, rdataN_o          one-cycle read-valid pulse, registered data
//   data_mem_*                   memory port, driven only during a beat
//   busy_o                       arbiter is in an OWN state
//
// Configuration
//   DATA_MEM_ARB_BURST_LIMIT_EN  when defined, an owner is preempted after
//                                BURST_MAX beats if the other port waits.
module data_mem_arb #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              data_mem_rd_enb_o,
    output logic              data_mem_wr_enb_o,
    output logic [ADDR_W-1:0] data_mem_addr_o,
    output logic [DATA_W-1:0] data_mem_wr_data_o,
    input  logic [DATA_W-1:0] data_mem_rd_data_i,
    output logic              busy_o
);

    if (BURST_MAX < 1 || BURST_MAX > 16) begin : g_bad_burst_max
        $error("data_mem_arb: BURST_MAX must be in 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;     // port that owned most recently
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic beat0, beat1;
    logic limit0, limit1;                  // burst limit forces a handover

    assign beat0 = (state_q == S_OWN0) && req0_i;
    assign beat1 = (state_q == S_OWN1) && req1_i;

`ifdef DATA_MEM_ARB_BURST_LIMIT_EN
    logic [4:0] cnt_q, cnt_d;
    logic       cnt_last;

    assign cnt_last = (cnt_q == 5'(BURST_MAX - 1));
    assign limit0   = beat0 && cnt_last && req1_i;
    assign limit1   = beat1 && cnt_last && req0_i;

    // Counts beats of the current owner; wraps at BURST_MAX whether or not
    // the other port was waiting, and clears on every ownership change.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (beat0 || beat1) begin
            cnt_d = cnt_last ? 5'd0 : cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign limit0 = 1'b0;
    assign limit1 = 1'b0;
`endif

    // Next state and round-robin history
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (req0_i && req1_i) state_d = last_q ? S_OWN0 : S_OWN1;
                else if (req0_i)      state_d = S_OWN0;
                else if (req1_i)      state_d = S_OWN1;
            end
            S_OWN0: begin
                if (!req0_i || limit0) begin
                    last_d  = 1'b0;
                    state_d = req1_i ? S_OWN1 : S_IDLE;
                end
            end
            S_OWN1: begin
                if (!req1_i || limit1) begin
                    last_d  = 1'b1;
                    state_d = req0_i ? S_OWN0 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port: driven from the owner only when a beat occurs, else 0
    always_comb begin
        data_mem_rd_enb_o  = 1'b0;
        data_mem_wr_enb_o  = 1'b0;
        data_mem_addr_o    = '0;
        data_mem_wr_data_o = '0;
        if (beat0) begin
            data_mem_rd_enb_o  = ~we0_i;
            data_mem_wr_enb_o  = we0_i;
            data_mem_addr_o    = addr0_i;
            data_mem_wr_data_o = wdata0_i;
        end else if (beat1) begin
            data_mem_rd_enb_o  = ~we1_i;
            data_mem_wr_enb_o  = we1_i;
            data_mem_addr_o    = addr1_i;
            data_mem_wr_data_o = wdata1_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rvalid0_q <= beat0 && !we0_i;
            rvalid1_q <= beat1 && !we1_i;
            if (beat0 && !we0_i) rdata0_q <= data_mem_rd_data_i;
            if (beat1 && !we1_i) rdata1_q <= data_mem_rd_data_i;
        end
    end

    assign gnt0_o    = (state_q == S_OWN0);
    assign gnt1_o    = (state_q == S_OWN1);
    assign busy_o    = (state_q != S_IDLE);
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arb.sv
module tb_data_mem_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       rd_enb, wr_enb;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_arb #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .data_mem_rd_enb_o(rd_enb), .data_mem_wr_enb_o(wr_enb),
        .data_mem_addr_o(m_addr), .data_mem_wr_data_o(m_wdata),
        .data_mem_rd_data_i(m_rdata),
        .busy_o(busy)
    );

    // Memory model: unwritten locations read as addr ^ 0x5A
    logic [7:0]   mem [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (wr_enb) begin
            mem[m_addr]     <= m_wdata;
            written[m_addr] <= 1'b1;
        end
    end
    assign m_rdata = written[m_addr] ? mem[m_addr] : (m_addr ^ 8'h5A);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int  b0, gnt1_cyc, last_beat_cyc, gap, b0_at_h;
    bit  done;

    initial begin
        // Reset held 3 cycles with both ports requesting
        rst = 1; req0 = 1; we0 = 0; addr0 = 8'h10; wdata0 = 0;
        req1 = 1; we1 = 0; addr1 = 8'h20; wdata1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_rvalid", {rvalid0, rvalid1}, 0);
            chk("rst_rdata", {rdata0, rdata1}, 0);
            chk("rst_mem_en", {rd_enb, wr_enb}, 0);
            chk("rst_busy", busy, 0);
        end
        rst = 0;
        tick();
        chk("first_tie_gnt0", gnt0, 1);
        chk("first_tie_gnt1", gnt1, 0);
        chk("beat_rd_enb", rd_enb, 1);
        chk("beat_addr", m_addr, 8'h10);
        req0 = 0; #1;
        chk("nobeat_rd_enb", rd_enb, 0);
        chk("nobeat_addr", m_addr, 0);
        tick();
        chk("handover_gnt1", gnt1, 1);
        chk("handover_gnt0", gnt0, 0);
        chk("handover_rv0", rvalid0, 0);
        tick();
        chk("p1_rvalid", rvalid1, 1);
        chk("p1_rdata", rdata1, 8'h7A);
        req1 = 0;
        tick();
        chk("p1_idle_busy", busy, 0);
        chk("p1_rv_drop", rvalid1, 0);
        chk("p1_rdata_hold", rdata1, 8'h7A);

        // Port 0 write 0xA5 to 0x3C, then read it back
        req0 = 1; we0 = 1; addr0 = 8'h3C; wdata0 = 8'hA5;
        tick();
        chk("wr_gnt0", gnt0, 1);
        chk("wr_enb", {rd_enb, wr_enb}, 2'b01);
        chk("wr_addr", m_addr, 8'h3C);
        chk("wr_data", m_wdata, 8'hA5);
        tick();
        req0 = 0;
        chk("wr_no_rvalid", rvalid0, 0);
        tick();
        chk("wr_idle", busy, 0);
        req0 = 1; we0 = 0;
        tick();
        chk("rd_gnt0", gnt0, 1);
        tick();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 8'hA5);
        chk("rd_gnt1_low", gnt1, 0);
        req0 = 0;
        tick();
        chk("rd_rvalid0_pulse", rvalid0, 0);
        chk("rd_rdata0_hold", rdata0, 8'hA5);

        // Short port 1 ownership so port 1 owned last
        req1 = 1;
        tick();
        chk("p1_touch_gnt1", gnt1, 1);
        req1 = 0;
        tick();

        // Tie from IDLE: port 0 first, then port 1 without a bubble
        req0 = 1; addr0 = 8'h05; req1 = 1; addr1 = 8'h06;
        tick();
        chk("tie_gnt0", gnt0, 1);
        chk("tie_gnt1", gnt1, 0);
        tick();
        chk("tie_rv0", rvalid0, 1);
        chk("tie_rd0", rdata0, 8'h5F);
        req0 = 0;
        tick();
        chk("tie_ho_gnt1", gnt1, 1);
        chk("tie_ho_gnt0", gnt0, 0);
        tick();
        chk("tie_rv1", rvalid1, 1);
        chk("tie_rd1", rdata1, 8'h5C);
        req1 = 0;
        tick();
        // Port 1 owned last -> port 0 wins
        req0 = 1; req1 = 1;
        tick();
        chk("tie2_gnt0", gnt0, 1);
        req0 = 0; req1 = 0;
        tick();
        // Port 0 owned last -> port 1 wins
        req0 = 1; req1 = 1;
        tick();
        chk("tie3_gnt1", gnt1, 1);
        chk("tie3_gnt0", gnt0, 0);
        req0 = 0; req1 = 0;
        tick();
        chk("tie3_idle", busy, 0);

        // Port 0 wants 10 beats while port 1 waits (port 0 wins the tie)
        req0 = 1; addr0 = 8'h80; req1 = 1; addr1 = 8'h90;
        b0 = 0; gnt1_cyc = -1; last_beat_cyc = -1; gap = -1; b0_at_h = -1; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (b0 == 10) begin
                req0 = 0;
                done = 1;
            end else begin
                if (gnt1 && gnt1_cyc < 0) begin
                    gnt1_cyc = c;
                    b0_at_h  = b0;
                    gap      = c - last_beat_cyc;
                    req1     = 0;
                end
                if (gnt0) begin
                    b0++;
                    last_beat_cyc = c;
                end
            end
        end
        chk("burst_done", done, 1);
        chk("burst_total", b0, 10);
        chk("burst_rdata0", rdata0, 8'hDA);
`ifdef DATA_MEM_ARB_BURST_LIMIT_EN
        chk("limit_beats", b0_at_h, 4);
        chk("limit_gap", gap, 1);
`else
        chk("nolimit_no_early_gnt1", gnt1_cyc, 32'hFFFF_FFFF);
        tick();
        chk("nolimit_gnt1", gnt1, 1);
`endif
        req1 = 0;
        tick();
        tick();
        chk("burst_idle", busy, 0);

        // Reset in the middle of a port 1 read burst
        req1 = 1; we1 = 0; addr1 = 8'h40;
        tick();
        chk("mid_gnt1", gnt1, 1);
        tick();
        chk("mid_rv1", rvalid1, 1);
        chk("mid_rd1", rdata1, 8'h1A);
        rst = 1;
        tick();
        chk("mid_rst_gnt1", gnt1, 0);
        chk("mid_rst_rv1", rvalid1, 0);
        chk("mid_rst_rd1", rdata1, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 0;
        tick();
        chk("post_rst_gnt1", gnt1, 1);
        req1 = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arb.md
# data_mem_arb

Two-port round-robin arbiter that shares the single-port 256 x 8b data memory between a core load/store port (port 0) and a DMA/debug port (port 1). It sits directly in front of the data memory, drives its read-enable, write-enable, address and write-data inputs, and returns registered read data with a valid pulse to the winning requester. Grants persist across back-to-back beats, forming bursts, and rotate fairly when both ports contend.

## Interface
- ADDR_W, 8, address width; matches data memory depth 256.
- DATA_W, 8, data width.
- BURST_MAX, 4, maximum beats per grant under contention; legal range 1..16. Used only when the burst limit is compiled in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_i / req1_i  in  1  port requests an access this cycle.
- we0_i / we1_i  in  1  1 = write, 0 = read; qualified by req.
- addr0_i / addr1_i  in  ADDR_W  access address.
- wdata0_i / wdata1_i  in  DATA_W  write data.
- gnt0_o / gnt1_o  out  1  port owns the memory this cycle; registered; one-hot or zero.
- rvalid0_o / rvalid1_o  out  1  one-cycle pulse; rdataN_o holds the read result.
- rdata0_o / rdata1_o  out  DATA_W  registered read data; holds until the next read for that port.
- data_mem_rd_enb_o  out  1  memory read enable.
- data_mem_wr_enb_o  out  1  memory write enable.
- data_mem_addr_o  out  ADDR_W  memory address.
- data_mem_wr_data_o  out  DATA_W  memory write data.
- data_mem_rd_data_i  in  DATA_W  combinational read data from the memory.
- busy_o  out  1  arbiter in an OWN state.

## Operation
- States: IDLE, OWN0, OWN1. gntN_o = (state == OWNN).
- Beat: owner's reqN_i high while in OWNN. The memory port is driven combinationally from the owner's inputs:
  - rd_enb = req & ~we
  - wr_enb = req & we
  - addr and wdata pass through from the owner.
- When no beat occurs, all four memory outputs are 0.
- Read beat: data_mem_rd_data_i is captured into rdataN_o at the clock edge; rvalidN_o pulses the following cycle.
- Write beat: the memory commits at the same edge. No response is returned.
- IDLE: if any req is high, go to OWN of the requester. On a tie, the port that did not own last wins. last_owner resets to 1, so port 0 wins the first tie.
- OWNx, reqx low: release. Go to OWN of the other port if its req is high, else IDLE. No beat occurs this cycle.
- OWNx, reqx high: beat. Stay in OWNx unless the burst limit fires.
- Requests seen while not granted are not serviced. The requester holds req, addr, we and wdata until it sees gnt.
- last_owner updates on every transition out of an OWN state.

## Timing
- Reset values: state IDLE, all gnt 0, rvalid 0, rdata 0, busy 0, beat counter 0, last_owner 1. All memory outputs 0.
- Grant latency: req rises at cycle N in IDLE -> gnt at N+1 -> first beat at N+1 -> rvalid at N+2 for a read.
- Back-to-back beats: 1 per cycle while granted; read responses follow in the same order, one cycle behind.
- Handover: the last beat of port x at cycle M -> gnt of port y at M+1. No idle bubble.
- Reset mid-burst: gnt drops and rvalid is forced to 0 in the next cycle; a captured-but-unreported read is discarded. A write on the reset edge still commits, because the memory is independent of this reset.
- Simultaneous first requests: exactly one gnt, chosen per last_owner.

## Configuration
- DATA_MEM_ARB_BURST_LIMIT_EN defined:
  - A beat counter counts beats of the current owner.
  - When the BURST_MAX-th beat completes while the other port requests, ownership moves to the other port next cycle, even if the owner still requests.
  - If the other port is not requesting, the counter clears and the owner continues.
  - The counter clears on any ownership change.
- Undefined: no counter; the owner keeps the grant until it drops req. Starvation is possible.

## Test plan
- Reset: hold rst 3 cycles with both req high -> all gnt 0, rvalid 0, rdata 0x00, memory enables 0; first cycle after reset gnt0=1.
- Single write then read: port 0 writes 0xA5 to 0x3C, drops req, then reads 0x3C -> rdata0_o=0xA5 with rvalid0_o one cycle after the read beat; gnt1 stays 0.
- Contention tie from IDLE: both request reads on the same cycle -> port 0 granted first; after it drops req, gnt1 rises the next cycle with no bubble; the next tie goes to port 0 again only if port 1 owned last.
- Burst limit (macro on, BURST_MAX=4): port 0 holds req for 10 beats while port 1 requests -> port 0 gets 4 beats, port 1 is granted in the cycle after the 4th beat.
- Burst limit off (macro off): same stimulus -> port 0 gets all 10 beats, then port 1 is granted.
- Reset mid-burst: assert rst during a port 1 read burst -> gnt1 and rvalid1 are 0 the next cycle; the arbiter returns to IDLE and rdata1_o=0.
